// File: rtl/fft_modulus_calc_if.sv
// Streaming bundle for the squared-modulus stage: complex FFT samples in,
// unsigned re^2+im^2 out, each side with its own valid/ready handshake.
interface fft_modulus_calc_if #(
    parameter int DW = 16
);
    logic                 s_valid;
    logic signed [DW-1:0] s_re;
    logic signed [DW-1:0] s_im;
    logic                 s_last;
    logic                 s_ready;
    logic                 m_valid;
    logic [2*DW-1:0]      m_data;
    logic                 m_last;
    logic                 m_ready;

    modport slave (
        input  s_valid, s_re, s_im, s_last, m_ready,
        output s_ready, m_valid, m_data, m_last
    );

    modport master (
        output s_valid, s_re, s_im, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_last
    );
endinterface

// File: rtl/fft_modulus_calc.sv
// Three-stage elastic pipeline computing |X|^2 = re^2 + im^2 per FFT bin,
// with a frame-length monitor that raises a sticky error on bad frame sizes.
module fft_modulus_calc #(
    parameter int DW = 16,
    parameter int N  = 1024,
    parameter int CW = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    fft_modulus_calc_if.slave    bus,
    output logic                 len_err
);

    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

    // Stage valid bits
    logic v1_reg;
    logic v2_reg;
    logic v3_reg;

    // Stage 1: captured operands
    logic signed [DW-1:0] re1_reg;
    logic signed [DW-1:0] im1_reg;
    logic                 last1_reg;

    // Stage 2: squares (non-negative, so the sign bit is dropped)
    logic [2*DW-2:0] sq_re2_reg;
    logic [2*DW-2:0] sq_im2_reg;
    logic            last2_reg;

    // Stage 3: sum
    logic [2*DW-1:0] sum3_reg;
    logic            last3_reg;

    // Frame-length monitor
    logic [CW-1:0] cnt_reg;
    logic          len_err_reg;

    // Each stage may load when it is empty or its content is leaving.
    logic load1;
    logic load2;
    logic load3;
    logic s_ready_int;
    logic in_xfer;

    assign load3       = ~v3_reg | bus.m_ready;
    assign load2       = ~v2_reg | load3;
    assign load1       = ~v1_reg | load2;
    assign s_ready_int = ~rst & load1;
    assign in_xfer     = bus.s_valid & s_ready_int;

    assign bus.s_ready = s_ready_int;
    assign bus.m_valid = v3_reg & ~rst;
    assign bus.m_data  = sum3_reg;
    assign bus.m_last  = last3_reg;
    assign len_err     = len_err_reg;

    // Sign-extend before multiplying so the full 2*DW product is formed.
    logic signed [2*DW-1:0] re_ext;
    logic signed [2*DW-1:0] im_ext;
    logic signed [2*DW-1:0] prod_re;
    logic signed [2*DW-1:0] prod_im;
    logic [2*DW-1:0]        sum_next;

    assign re_ext   = {{DW{re1_reg[DW-1]}}, re1_reg};
    assign im_ext   = {{DW{im1_reg[DW-1]}}, im1_reg};
    assign prod_re  = re_ext * re_ext;
    assign prod_im  = im_ext * im_ext;
    assign sum_next = {1'b0, sq_re2_reg} + {1'b0, sq_im2_reg};

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_reg    <= 1'b0;
            re1_reg   <= '0;
            im1_reg   <= '0;
            last1_reg <= 1'b0;
        end else if (load1) begin
            v1_reg <= bus.s_valid;
            if (bus.s_valid) begin
                re1_reg   <= bus.s_re;
                im1_reg   <= bus.s_im;
                last1_reg <= bus.s_last;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v2_reg     <= 1'b0;
            sq_re2_reg <= '0;
            sq_im2_reg <= '0;
            last2_reg  <= 1'b0;
        end else if (load2) begin
            v2_reg <= v1_reg;
            if (v1_reg) begin
                sq_re2_reg <= prod_re[2*DW-2:0];
                sq_im2_reg <= prod_im[2*DW-2:0];
                last2_reg  <= last1_reg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v3_reg    <= 1'b0;
            sum3_reg  <= '0;
            last3_reg <= 1'b0;
        end else if (load3) begin
            v3_reg <= v2_reg;
            if (v2_reg) begin
                sum3_reg  <= sum_next;
                last3_reg <= last2_reg;
            end
        end
    end

    // An overrun (N beats without last) flags an error and starts a new frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg     <= '0;
            len_err_reg <= 1'b0;
        end else if (in_xfer) begin
            if (bus.s_last) begin
                cnt_reg <= '0;
                if (cnt_reg != LAST_IDX) begin
                    len_err_reg <= 1'b1;
                end
            end else if (cnt_reg == LAST_IDX) begin
                cnt_reg     <= '0;
                len_err_reg <= 1'b1;
            end else begin
                cnt_reg <= cnt_reg + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fft_modulus_calc.sv
// Self-checking bench: table-driven latency/arithmetic vectors, directed
// backpressure, frame-length and reset sequences, then a random stream.
module tb_fft_modulus_calc;

    localparam int DW = 16;
    localparam int N  = 8;
    localparam int CW = 3;

    logic clk;
    logic rst;
    logic len_err;

    fft_modulus_calc_if #(.DW(DW)) bus ();

    fft_modulus_calc #(.DW(DW), .N(N), .CW(CW)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .len_err (len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_out    = 0;

    logic [2*DW:0] sb[$];
    logic          stall_prev;
    logic [2*DW:0] hold_beat;

    typedef struct {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
        logic                 last;
        logic [2*DW-1:0]      expd;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input bit ok, input string name,
                         input logic [63:0] act, input logic [63:0] expd);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expd, $time);
        end
    endtask

    function automatic logic [2*DW-1:0] model(input logic signed [DW-1:0] re,
                                              input logic signed [DW-1:0] im);
        longint a;
        longint b;
        logic [63:0] r;
        a = re;
        b = im;
        r = a * a + b * b;
        return r[2*DW-1:0];
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic do_reset();
        cyc();
        rst = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_last = 1'b0;
        bus.m_ready = 1'b0;
        cyc();
        rst = 1'b0;
    endtask

    function automatic logic signed [DW-1:0] beat_re(input int k);
        return DW'(k * 1000 - 5000);
    endfunction

    function automatic logic signed [DW-1:0] beat_im(input int k);
        return DW'(7 - 3 * k);
    endfunction

    // Scoreboard: pops before pushing so a zero-latency path cannot match.
    task automatic monitor();
        logic [2*DW:0] e;
        stall_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check(bus.m_valid === 1'b1 && {bus.m_last, bus.m_data} === hold_beat,
                          "stall_hold", {bus.m_valid, bus.m_last, bus.m_data}, {1'b1, hold_beat});
                end
                if (bus.m_valid && bus.m_ready) begin
                    check(sb.size() != 0, "stale_beat", 64'(sb.size()), 64'd1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check({bus.m_last, bus.m_data} === e, "sb_beat",
                              {bus.m_last, bus.m_data}, e);
                    end
                    $display("out %0d: data=%08h last=%0b", n_out, bus.m_data, bus.m_last);
                    n_out++;
                end
                if (bus.s_valid && bus.s_ready) begin
                    sb.push_back({bus.s_last, model(bus.s_re, bus.s_im)});
                end
                stall_prev = bus.m_valid && !bus.m_ready;
                hold_beat  = {bus.m_last, bus.m_data};
            end
        end
    endtask

    initial begin
        int acc;
        int outs;
        int gaps;
        int cnt_c;
        int sent;
        bit accepted;

        vecs[0] = '{re: 16'sd3,      im: -16'sd4,     last: 1'b0, expd: 32'd25};
        vecs[1] = '{re: -16'sd32768, im: -16'sd32768, last: 1'b0, expd: 32'h8000_0000};
        vecs[2] = '{re: 16'sd32767,  im: 16'sd0,      last: 1'b0, expd: 32'h3FFF_0001};
        vecs[3] = '{re: 16'sd0,      im: 16'sd0,      last: 1'b0, expd: 32'd0};
        vecs[4] = '{re: -16'sd1,     im: 16'sd1,      last: 1'b0, expd: 32'd2};
        vecs[5] = '{re: 16'sd100,    im: -16'sd200,   last: 1'b0, expd: 32'd50000};
        vecs[6] = '{re: -16'sd32768, im: 16'sd32767,  last: 1'b0, expd: 32'h7FFF_0001};
        vecs[7] = '{re: 16'sd12345,  im: -16'sd6789,  last: 1'b1, expd: 32'd198489546};

        rst = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_re = '0;
        bus.s_im = '0;
        bus.s_last = 1'b0;
        bus.m_ready = 1'b0;
        fork
            monitor();
        join_none

        // Reset state
        smp();
        check(bus.m_valid === 1'b0, "rst_m_valid", 64'(bus.m_valid), 64'd0);
        check(bus.s_ready === 1'b0, "rst_s_ready", 64'(bus.s_ready), 64'd0);
        check(len_err === 1'b0, "rst_len_err", 64'(len_err), 64'd0);
        check(bus.m_data === '0, "rst_m_data", 64'(bus.m_data), 64'd0);
        cyc();
        rst = 1'b0;
        smp();
        check(bus.s_ready === 1'b1, "post_rst_s_ready", 64'(bus.s_ready), 64'd1);

        // Single beats: latency 3, one cycle of m_valid, exact arithmetic
        for (int i = 0; i < 8; i++) begin
            cyc();
            bus.m_ready = 1'b1;
            bus.s_valid = 1'b1;
            bus.s_re = vecs[i].re;
            bus.s_im = vecs[i].im;
            bus.s_last = vecs[i].last;
            smp();
            check(bus.s_ready === 1'b1, "tbl_accept", 64'(bus.s_ready), 64'd1);
            for (int k = 1; k <= 4; k++) begin
                cyc();
                bus.s_valid = 1'b0;
                smp();
                check(bus.m_valid === (k == 3), "tbl_latency", 64'(bus.m_valid), 64'(k == 3));
                if (k == 3) begin
                    check(bus.m_data === vecs[i].expd, "tbl_data", 64'(bus.m_data), 64'(vecs[i].expd));
                    check(bus.m_last === vecs[i].last, "tbl_last", 64'(bus.m_last), 64'(vecs[i].last));
                end
            end
        end
        check(len_err === 1'b0, "tbl_frame_len_err", 64'(len_err), 64'd0);

        // Backpressure: only 3 beats fit while m_ready is low
        do_reset();
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            cyc();
            bus.s_valid = 1'b1;
            bus.s_last = 1'b0;
            bus.s_re = beat_re(acc);
            bus.s_im = beat_im(acc);
            smp();
            if (c >= 3) begin
                check(bus.s_ready === 1'b0, "bp_s_ready_low", 64'(bus.s_ready), 64'd0);
            end
            if (bus.s_ready) acc++;
        end
        check(acc == 3, "bp_accepted", 64'(acc), 64'd3);
        outs = 0;
        gaps = 0;
        cnt_c = 0;
        while (outs < 10 && cnt_c < 40) begin
            cyc();
            bus.m_ready = 1'b1;
            bus.s_valid = (acc < 10);
            bus.s_re = beat_re(acc);
            bus.s_im = beat_im(acc);
            smp();
            if (bus.s_valid && bus.s_ready) acc++;
            if (bus.m_valid) outs++;
            else gaps++;
            cnt_c++;
        end
        check(outs == 10, "bp_outputs", 64'(outs), 64'd10);
        check(gaps == 0, "bp_gaps", 64'(gaps), 64'd0);
        cyc();
        bus.s_valid = 1'b0;
        smp();
        check(sb.size() == 0, "bp_drained", 64'(sb.size()), 64'd0);

        // Two well-formed frames of N beats
        do_reset();
        bus.m_ready = 1'b1;
        for (int b = 0; b < 2 * N; b++) begin
            cyc();
            bus.s_valid = 1'b1;
            bus.s_last = (b % N == N - 1);
            bus.s_re = beat_re(b);
            bus.s_im = beat_im(b);
            smp();
            check(bus.s_ready === 1'b1, "frame_s_ready", 64'(bus.s_ready), 64'd1);
        end
        cyc();
        bus.s_valid = 1'b0;
        bus.s_last = 1'b0;
        smp();
        check(len_err === 1'b0, "frame_ok_len_err", 64'(len_err), 64'd0);

        // Short frame of 5 beats
        for (int b = 0; b < 5; b++) begin
            cyc();
            bus.s_valid = 1'b1;
            bus.s_last = (b == 4);
            bus.s_re = beat_re(b + 3);
            bus.s_im = beat_im(b);
            smp();
            check(len_err === 1'b0, "short_len_err_pre", 64'(len_err), 64'd0);
        end
        cyc();
        bus.s_valid = 1'b0;
        bus.s_last = 1'b0;
        smp();
        check(len_err === 1'b1, "short_len_err_set", 64'(len_err), 64'd1);
        repeat (3) cyc();
        smp();
        check(len_err === 1'b1, "short_len_err_sticky", 64'(len_err), 64'd1);

        // Overrun: N beats without last
        do_reset();
        bus.m_ready = 1'b1;
        for (int b = 0; b <= N; b++) begin
            cyc();
            bus.s_valid = 1'b1;
            bus.s_last = 1'b0;
            bus.s_re = beat_re(b);
            bus.s_im = beat_im(b + 1);
            smp();
            if (b == N - 1) check(len_err === 1'b0, "ovr_len_err_pre", 64'(len_err), 64'd0);
            if (b == N)     check(len_err === 1'b1, "ovr_len_err_set", 64'(len_err), 64'd1);
        end

        // Reset while all stages are full and stalled
        for (int c = 0; c < 4; c++) begin
            cyc();
            bus.m_ready = 1'b0;
            bus.s_valid = 1'b1;
            bus.s_re = beat_re(c);
            bus.s_im = beat_im(c);
            smp();
        end
        check(bus.m_valid === 1'b1 && bus.s_ready === 1'b0, "stall_full",
              {bus.m_valid, bus.s_ready}, 64'b10);
        cyc();
        rst = 1'b1;
        bus.s_valid = 1'b0;
        smp();
        check(bus.m_valid === 1'b0 && bus.s_ready === 1'b0, "in_rst_outputs",
              {bus.m_valid, bus.s_ready}, 64'b00);
        cyc();
        rst = 1'b0;
        smp();
        check(bus.m_valid === 1'b0, "rst_flush_m_valid", 64'(bus.m_valid), 64'd0);
        check(bus.s_ready === 1'b1, "rst_flush_s_ready", 64'(bus.s_ready), 64'd1);
        check(len_err === 1'b0, "rst_flush_len_err", 64'(len_err), 64'd0);
        for (int c = 0; c < 6; c++) begin
            cyc();
            bus.m_ready = 1'b1;
            smp();
            check(bus.m_valid === 1'b0, "no_stale_beat", 64'(bus.m_valid), 64'd0);
        end

        // Random handshakes; a beat is held until accepted
        do_reset();
        sent = 0;
        cnt_c = 0;
        accepted = 1'b0;
        while (sent < 10000 && cnt_c < 60000) begin
            cyc();
            if (!bus.s_valid || accepted) begin
                bus.s_valid = 1'($urandom_range(0, 1));
                bus.s_re = DW'($urandom);
                bus.s_im = DW'($urandom);
                bus.s_last = ($urandom_range(0, 7) == 0);
            end
            bus.m_ready = 1'($urandom_range(0, 1));
            smp();
            accepted = bus.s_valid && bus.s_ready;
            if (accepted) sent++;
            cnt_c++;
        end
        check(sent == 10000, "rand_budget", 64'(sent), 64'd10000);
        cyc();
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b1;
        cnt_c = 0;
        while (sb.size() != 0 && cnt_c < 20) begin
            cyc();
            cnt_c++;
        end
        smp();
        check(sb.size() == 0, "rand_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
